// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module : conv_window_gen
// Streaming 3x3 sliding-window generator (two row line buffers, no padding).
// Optional synchronous frame restart input 'clear' when CONV_WIN_CLEAR_EN.
// Rev    : 1.0  initial release
// ============================================================================
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CONV_WIN_CLEAR_EN
  input  logic       clear,
`endif
  input  logic [7:0] in_pix,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] W0,
  output logic [7:0] W1,
  output logic [7:0] W2,
  output logic [7:0] W3,
  output logic [7:0] W4,
  output logic [7:0] W5,
  output logic [7:0] W6,
  output logic [7:0] W7,
  output logic [7:0] W8,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam int c_col_w = $clog2(IMG_W);
  localparam int c_row_w = $clog2(IMG_H);

  logic [c_col_w-1:0]    r_col;
  logic [c_row_w-1:0]    r_row;
  logic [IMG_W-1:0][7:0] r_lb0;
  logic [IMG_W-1:0][7:0] r_lb1;
  logic [7:0]            r_win [9];
  logic                  r_out_valid;
  logic                  r_out_last;

  logic       w_clear;
  logic       w_accept;
  logic       w_pos_valid;
  logic       w_col_end;
  logic       w_row_end;
  logic [7:0] w_lb0_out;
  logic [7:0] w_lb1_out;

`ifdef CONV_WIN_CLEAR_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif

  assign in_ready    = rst && (!r_out_valid || out_ready);
  // A pixel arriving together with clear is dropped.
  assign w_accept    = in_valid && in_ready && !w_clear;
  assign w_col_end   = (r_col == c_col_w'(IMG_W - 1));
  assign w_row_end   = (r_row == c_row_w'(IMG_H - 1));
  assign w_pos_valid = (r_row >= c_row_w'(2)) && (r_col >= c_col_w'(2));
  assign w_lb0_out   = r_lb0[IMG_W-1];
  assign w_lb1_out   = r_lb1[IMG_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_clear) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= w_pos_valid;
      r_out_last  <= w_pos_valid && w_row_end && w_col_end;
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + c_row_w'(1);
      end else begin
        r_col <= r_col + c_col_w'(1);
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Stale rows from a previous frame only occupy positions that the
  // row>=2 && col>=2 qualifier never exposes, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1 <= {r_lb1[IMG_W-2:0], in_pix};
      r_lb0 <= {r_lb0[IMG_W-2:0], w_lb1_out};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_lb0_out;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_lb1_out;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= in_pix;
    end
  end

  assign W0        = r_win[0];
  assign W1        = r_win[1];
  assign W2        = r_win[2];
  assign W3        = r_win[3];
  assign W4        = r_win[4];
  assign W5        = r_win[5];
  assign W6        = r_win[6];
  assign W7        = r_win[7];
  assign W8        = r_win[8];
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 sliding-window generator that feeds the pipelined 3x3 convolution MAC. It accepts one 8-bit pixel per handshake in raster order, buffers two image rows, and presents the nine window pixels W0..W8 in the same row-major order as the MAC's X0..X8 inputs. A window is emitted only when it lies fully inside the image: no padding, (IMG_W-2)*(IMG_H-2) windows per frame.

## Interface
- IMG_W, default 8: pixels per row; legal range 3..1024.
- IMG_H, default 8: rows per frame; legal range 3..1024.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_pix  in  8  input pixel, unsigned.
- in_valid  in  1  in_pix is valid.
- in_ready  out  1  block can accept a pixel.
- W0..W8  out  8 each  window pixels.
  - W0 is the top-left pixel (row r-2, col c-2).
  - W8 is the bottom-right pixel, which is the most recently accepted pixel (r, c).
- out_valid  out  1  W0..W8 hold a valid window.
- out_ready  in  1  downstream accepts the window.
- out_last  out  1  qualifies the final window of the frame.
- clear  in  1  synchronous frame restart (present only with CONV_WIN_CLEAR_EN).

## Operation
- Accept: a pixel is accepted when in_valid && in_ready.
- in_ready = rst && (!out_valid || out_ready). This is combinational, and is 0 while rst is low.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1, both advanced per accepted pixel.
  - col wraps to 0 after IMG_W-1, and row increments at that point.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0. The next accepted pixel starts a new frame with no idle cycle.
- Line buffers: two IMG_W-deep delay lines (LB1 = previous row, LB0 = row before that), either shift registers or RAM with a shared pointer.
  - On accept, LB0 takes the LB1 output and LB1 takes in_pix.
- Window registers: a 3x3 register array. On accept, each row shifts left by one column. The new right column is (LB0 out, LB1 out, in_pix) for rows top, middle, bottom.
- Window valid: out_valid is set on an accept at row>=2 && col>=2, using counter values before the increment.
- Stale data: line-buffer contents left over from the previous frame never reach a valid window.
- out_valid next-state:
  - accept && position valid: 1.
  - accept && !position valid: 0.
  - !accept && out_ready: 0.
  - otherwise: hold.
- out_last is registered with out_valid and is 1 only for the window at (IMG_H-1, IMG_W-1).
- Backpressure: while out_valid && !out_ready, W0..W8, out_valid and out_last hold and in_ready is 0.
- Arithmetic: no arithmetic on pixel data. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide.

## Timing
- Latency: a window appears 1 cycle after the accept of its bottom-right pixel.
- Throughput: with out_ready held at 1, one pixel per cycle is accepted and one window per cycle is produced.
- Reset (rst low, asynchronous): W0..W8 = 0, out_valid = 0, out_last = 0, row = col = 0, in_ready = 0.
  - Line buffers need not be reset.
  - Reset mid-frame discards the partial frame. The first pixel after reset is treated as (0,0).
- Simultaneous events: out_ready and an accept in the same cycle give an unbroken stream. The window is consumed and replaced by the next window, or cleared.
- Startup: the first window of a frame follows the accept of pixel index 2*IMG_W+2.

## Configuration
- CONV_WIN_CLEAR_EN defined:
  - Adds the clear input. When clear is 1 at a clock edge, row and col go to 0, out_valid and out_last go to 0, and W* hold.
  - clear has priority over a simultaneous accept, and that pixel is dropped.
- CONV_WIN_CLEAR_EN undefined: no clear port. The frame position can be reset only by rst.

## Test plan
Scenarios 1-3 and 5 use IMG_W = IMG_H = 4, with pixels p = 4r + c + 1 (values 1..16).
1. Reset: drive rst low mid-stream -> all outputs are 0 immediately (asynchronous). After release, the stream restarts at (0,0) and produces the same windows as scenario 2.
2. Single frame streamed with out_ready = 1 -> exactly 4 windows.
   - First window 1,2,3,5,6,7,9,10,11, one cycle after pixel 11 is accepted.
   - Second window 2,3,4,6,7,8,10,11,12.
   - Last window 6,7,8,10,11,12,14,15,16, with out_last = 1.
3. Two back-to-back frames, second frame pixels = p+100 -> the second frame's first window is 101,102,103,105,106,107,109,110,111, with no stale first-frame data.
4. Backpressure: hold out_ready = 0 for 5 cycles after the first window -> W* and out_valid are stable, in_ready = 0, and no pixel is lost. Windows then resume in order.
5. Random in_valid gaps (about 50%) with random out_ready -> the window sequence is identical to scenario 2.
6. With CONV_WIN_CLEAR_EN: pulse clear after 7 accepted pixels, then send a full frame -> exactly 4 windows, matching scenario 2.
